program_loader: RTL
===================

# program_loader

Byte-stream instruction loader that writes a program into the CPU's instruction memory write port (wr_en / wr_addr / wr_data) and then releases the CPU by pulsing go. It sits between an external byte source (UART or bench) and the CPU top level. It replaces bench-driven memory preload with a self-contained, framed load protocol.

## Interface
- INSTR_LEN, 20, instruction width in bits; must be ≤ 24 (packed into 3 bytes)
- ADDR, 5, instruction memory address width; must be ≤ 8; capacity DEPTH = 2**ADDR words
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- start  input  1  request a new load; sampled only in IDLE or DONE
- in_valid  input  1  byte source has in_data available
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts in_data this cycle
- wr_en  output  1  memory write strobe
- wr_addr  output  ADDR  memory write address
- wr_data  output  INSTR_LEN  memory write data
- go  output  1  one-cycle CPU start pulse
- busy  output  1  high in HDR, B0, B1, B2, WRITE and GO
- load_done  output  1  high in DONE
- format_err  output  1  sticky: a word carried nonzero bits above INSTR_LEN
- length_err  output  1  sticky: header count was 0 or > DEPTH

## Operation
- Frame: header byte N (word count), then N words of 3 bytes each, big-endian. Word = {b0, b1, b2}[INSTR_LEN-1:0].
- Byte transfer occurs on an edge where in_valid && in_ready. in_ready = 1 only in HDR, B0, B1, B2, independent of in_valid.
- States:
  - IDLE: start → HDR; clear format_err, length_err and word index idx.
  - HDR: on transfer latch N; N = 0 or N > DEPTH → set length_err, go to IDLE with no writes; else → B0.
  - B0 / B1 / B2: on transfer, store the byte and advance to the next state; B2 → WRITE. No transfer → hold.
  - WRITE: wr_en = 1, wr_addr = idx, wr_data = assembled word. If any of bits [23:INSTR_LEN] of the 24-bit word is set, set format_err; the write still happens. If idx == N-1 → GO; else idx++ → B0.
  - GO: go = 1 for exactly one cycle → DONE.
  - DONE: load_done = 1, held until start, which clears both error flags and idx and moves to HDR.
- start is ignored while busy.
- The N counter and idx are ADDR+1 bits wide so that N = DEPTH is representable. Addresses are written 0..N-1 in order with no wrap.
- wr_addr and wr_data hold their last values outside WRITE; only wr_en qualifies them.

## Timing
- Reset values: state IDLE; in_ready, wr_en, go, busy, load_done, format_err, length_err = 0; wr_addr = 0; wr_data = 0; idx = 0.
- A reset mid-load returns to IDLE in the next cycle with no further writes. Words already written remain in memory.
- Latency: if the third byte of a word transfers at edge k, wr_en is high during cycle k+1 and in_ready rises again in cycle k+2. Peak throughput is 1 word per 4 cycles.
- Last word: WRITE is in cycle k+1, go in cycle k+2, and load_done rises in cycle k+3.
- length_err is visible in the cycle after the header transfer, together with the return to IDLE.
- Stalls: in_valid low in any byte state holds state, with no timeout. Bytes presented while in_ready = 0 are not consumed.

## Test plan
- Basic load (INSTR_LEN 20, ADDR 5): stream 0x02, 0x0A,0xBC,0xDE, 0x01,0x23,0x45 with in_valid held high → writes addr 0 = 0xABCDE and addr 1 = 0x12345, each a one-cycle wr_en 4 cycles apart; go pulses once 1 cycle after the second write; load_done then holds; format_err = 0.
- Backpressure: same stream with in_valid toggling randomly → identical writes, and no byte is consumed while in_ready = 0.
- Length errors: header 0x00 → length_err = 1, back to IDLE, no wr_en, no go. Header 0x21 (33) → same. Header 0x20 (32) followed by 96 bytes → 32 writes at addr 0..31, then go.
- Format error: word bytes 0xF0,0x00,0x01 → write of 0x00001 with format_err = 1, still set in DONE. The next start clears it.
- Reset mid-word: assert reset after B1 of the second word → next cycle IDLE with all outputs at reset values and no write to addr 1. A fresh start-and-load then succeeds.
- start while busy: pulse start during B1 → no effect; the load completes normally.

Source files
------------

// File: rtl/program_loader.sv
// Framed byte-stream loader: header N, then N big-endian 3-byte words written
// to instruction memory at addresses 0..N-1, followed by a one-cycle go pulse.
module program_loader #(
    parameter int INSTR_LEN = 20,
    parameter int ADDR      = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 wr_en,
    output logic [ADDR-1:0]      wr_addr,
    output logic [INSTR_LEN-1:0] wr_data,
    output logic                 go,
    output logic                 busy,
    output logic                 load_done,
    output logic                 format_err,
    output logic                 length_err
);

    localparam int            DEPTH = 2 ** ADDR;
    localparam logic [ADDR:0] ONE   = (ADDR + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_B0, S_B1, S_B2, S_WRITE, S_GO, S_DONE
    } state_t;

    state_t        r_state;
    logic [ADDR:0] r_n;
    logic [ADDR:0] r_idx;
    logic [7:0]    r_b0;
    logic [7:0]    r_b1;

    logic          w_xfer;
    logic [23:0]   w_word;

    assign w_xfer = in_valid && in_ready;
    // Third byte is taken straight from the bus so the word is ready at WRITE entry.
    assign w_word = {r_b0, r_b1, in_data};

    assign in_ready  = (r_state inside {S_HDR, S_B0, S_B1, S_B2});
    assign wr_en     = (r_state == S_WRITE);
    assign go        = (r_state == S_GO);
    assign busy      = (r_state inside {S_HDR, S_B0, S_B1, S_B2, S_WRITE, S_GO});
    assign load_done = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_idx      <= '0;
            r_b0       <= '0;
            r_b1       <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            format_err <= 1'b0;
            length_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_HDR;
                        r_idx      <= '0;
                        format_err <= 1'b0;
                        length_err <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (w_xfer) begin
                        r_n <= (ADDR + 1)'(in_data);
                        if (in_data == 8'd0 || 32'(in_data) > DEPTH) begin
                            length_err <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_state <= S_B0;
                        end
                    end
                end
                S_B0: begin
                    if (w_xfer) begin
                        r_b0    <= in_data;
                        r_state <= S_B1;
                    end
                end
                S_B1: begin
                    if (w_xfer) begin
                        r_b1    <= in_data;
                        r_state <= S_B2;
                    end
                end
                S_B2: begin
                    if (w_xfer) begin
                        wr_addr <= r_idx[ADDR-1:0];
                        wr_data <= w_word[INSTR_LEN-1:0];
                        if ((w_word >> INSTR_LEN) != 24'd0)
                            format_err <= 1'b1;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_idx == r_n - ONE) begin
                        r_state <= S_GO;
                    end else begin
                        r_idx   <= r_idx + ONE;
                        r_state <= S_B0;
                    end
                end
                S_GO:    r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
